// File: rtl/fbig_input_pkg.sv
// rtl/fbig_input_pkg.sv - shared action/direction types and the per-player HID keymap
package fbig_input_pkg;

    typedef enum logic [1:0] {
        ACT_LEFT  = 2'd0,
        ACT_RIGHT = 2'd1,
        ACT_JUMP  = 2'd2
    } action_t;

    typedef enum logic [1:0] {
        DIR_IDLE  = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_RIGHT = 2'd2
    } dir_state_t;

    localparam logic [7:0] HID_ERR_ROLLOVER = 8'h01;

    // KEYMAP[player][action]: arrows, WASD, IJL, numpad 4/6/8
    localparam logic [0:3][0:2][7:0] KEYMAP = {
        8'h50, 8'h4F, 8'h52,
        8'h04, 8'h07, 8'h1A,
        8'h0D, 8'h0F, 8'h0C,
        8'h5C, 8'h5E, 8'h60
    };

endpackage

// File: rtl/player_input_channel.sv
// rtl/player_input_channel.sv - one player's left/right resolver FSM and buffered jump request
module player_input_channel
    import fbig_input_pkg::*;
#(
    parameter int JUMP_BUF_FRAMES = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] hit,
    input  logic       tick,
    input  logic       jump_ack,
    output logic       move_left,
    output logic       move_right,
    output logic       jump_req
);

    dir_state_t state, state_next;
    logic [2:0] prev_hit, prev_hit_next;
    logic [2:0] new_hit;
    logic       jump_req_next;
    logic [3:0] cnt, cnt_next;

    assign new_hit = hit & ~prev_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= DIR_IDLE;
            prev_hit <= '0;
            jump_req <= 1'b0;
            cnt      <= '0;
        end else begin
            state    <= state_next;
            prev_hit <= prev_hit_next;
            jump_req <= jump_req_next;
            cnt      <= cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        prev_hit_next = prev_hit;
        jump_req_next = jump_req;
        cnt_next      = cnt;
        if (tick) begin
            prev_hit_next = hit;
            case ({hit[ACT_LEFT], hit[ACT_RIGHT]})
                2'b10:   state_next = DIR_LEFT;
                2'b01:   state_next = DIR_RIGHT;
                2'b00:   state_next = DIR_IDLE;
                default: begin
                    // both held: the most recent press wins, a tie keeps the current direction
                    if (new_hit[ACT_LEFT] && !new_hit[ACT_RIGHT])
                        state_next = DIR_LEFT;
                    else if (new_hit[ACT_RIGHT] && !new_hit[ACT_LEFT])
                        state_next = DIR_RIGHT;
                end
            endcase
        end
        if (tick && new_hit[ACT_JUMP]) begin
            jump_req_next = 1'b1;
            cnt_next      = 4'(JUMP_BUF_FRAMES);
        end else if (jump_ack && jump_req) begin
            jump_req_next = 1'b0;
            cnt_next      = '0;
        end else if (tick && jump_req) begin
            cnt_next = cnt - 4'd1;
            if (cnt == 4'd1)
                jump_req_next = 1'b0;
        end
    end

    assign move_left  = (state == DIR_LEFT);
    assign move_right = (state == DIR_RIGHT);

endmodule

// File: rtl/multi_player_input_mapper.sv
// rtl/multi_player_input_mapper.sv - HID report latch, keymap decode, frame retiming; STUCK_KEY_TIMEOUT_EN adds auto-release
module multi_player_input_mapper
    import fbig_input_pkg::*;
#(
    parameter int NUM_SLOTS       = 6,
    parameter int NUM_PLAYERS     = 2,
    parameter int JUMP_BUF_FRAMES = 6,
    parameter int STUCK_FRAMES    = 255
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic [8*NUM_SLOTS-1:0]   keycodes,
    input  logic                     keycode_valid,
    input  logic                     frame_clk,
    input  logic [NUM_PLAYERS-1:0]   jump_ack,
    output logic [NUM_PLAYERS-1:0]   move_left,
    output logic [NUM_PLAYERS-1:0]   move_right,
    output logic [NUM_PLAYERS-1:0]   jump_req,
    output logic                     any_key
);

    logic [1:0]                   frame_sync;
    logic                         frame_sync_d;
    logic                         tick;
    logic [8*NUM_SLOTS-1:0]       report;
    logic                         rollover;
    logic                         accept;
    logic [NUM_PLAYERS-1:0][2:0]  hit;
    logic                         report_nz;
    logic                         report_nz_d;

    // frame_clk is asynchronous: two-flop sync, then a registered rising-edge pulse
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            frame_sync   <= '0;
            frame_sync_d <= 1'b0;
            tick         <= 1'b0;
        end else begin
            frame_sync   <= {frame_sync[0], frame_clk};
            frame_sync_d <= frame_sync[1];
            tick         <= frame_sync[1] & ~frame_sync_d;
        end
    end

    always_comb begin
        rollover = 1'b0;
        for (int s = 0; s < NUM_SLOTS; s++)
            if (keycodes[8*s +: 8] == HID_ERR_ROLLOVER)
                rollover = 1'b1;
    end

    assign accept = keycode_valid && !rollover;

`ifdef STUCK_KEY_TIMEOUT_EN
    logic [7:0] stuck_cnt;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            report    <= '0;
            stuck_cnt <= '0;
        end else if (accept) begin
            report    <= keycodes;
            stuck_cnt <= '0;
        end else begin
            if (tick && stuck_cnt != 8'hFF)
                stuck_cnt <= stuck_cnt + 8'd1;
            if (stuck_cnt == 8'(STUCK_FRAMES))
                report <= '0;
        end
    end
`else
    logic stuck_frames_unused;
    assign stuck_frames_unused = ^8'(STUCK_FRAMES);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            report <= '0;
        else if (accept)
            report <= keycodes;
    end
`endif

    always_comb begin
        hit = '0;
        for (int p = 0; p < NUM_PLAYERS; p++)
            for (int a = 0; a < 3; a++)
                for (int s = 0; s < NUM_SLOTS; s++)
                    if (report[8*s +: 8] == KEYMAP[p][a])
                        hit[p][a] = 1'b1;
    end

    assign report_nz = |report;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            report_nz_d <= 1'b0;
        else
            report_nz_d <= report_nz;
    end

    assign any_key = report_nz & ~report_nz_d;

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        player_input_channel #(
            .JUMP_BUF_FRAMES(JUMP_BUF_FRAMES)
        ) u_channel (
            .clk       (Clk),
            .rst_n     (Reset_n),
            .hit       (hit[p]),
            .tick      (tick),
            .jump_ack  (jump_ack[p]),
            .move_left (move_left[p]),
            .move_right(move_right[p]),
            .jump_req  (jump_req[p])
        );
    end

endmodule

// File: tb/tb_multi_player_input_mapper.sv
// tb/tb_multi_player_input_mapper.sv - directed and randomized checks of the multi-player input mapper
module tb_multi_player_input_mapper;

    localparam int NS  = 6;
    localparam int NP  = 4;
    localparam int JBF = 6;
    localparam int SF  = 3;

    logic            Clk = 1'b0;
    logic            Reset_n = 1'b0;
    logic [8*NS-1:0] keycodes = '0;
    logic            keycode_valid = 1'b0;
    logic            frame_clk = 1'b0;
    logic [NP-1:0]   jump_ack = '0;
    logic [NP-1:0]   move_left, move_right, jump_req;
    logic            any_key;

    int checks = 0;
    int fails  = 0;

    logic [7:0] m_rep [NS];
    int         m_dir [NP];
    bit         m_prev [NP][3];
    bit         m_jreq [NP];
    int         m_jcnt [NP];
    int         m_since;

    multi_player_input_mapper #(
        .NUM_SLOTS(NS), .NUM_PLAYERS(NP), .JUMP_BUF_FRAMES(JBF), .STUCK_FRAMES(SF)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .keycodes(keycodes), .keycode_valid(keycode_valid),
        .frame_clk(frame_clk), .jump_ack(jump_ack), .move_left(move_left),
        .move_right(move_right), .jump_req(jump_req), .any_key(any_key)
    );

    always #10 Clk = ~Clk;

    function automatic logic [7:0] km(input int p, input int a);
        logic [7:0] t [12];
        t = '{8'h50, 8'h4F, 8'h52, 8'h04, 8'h07, 8'h1A, 8'h0D, 8'h0F, 8'h0C, 8'h5C, 8'h5E, 8'h60};
        return t[3*p + a];
    endfunction

    function automatic logic [8*NS-1:0] mk(input logic [7:0] a, input logic [7:0] b);
        logic [8*NS-1:0] r;
        r = '0;
        r[7:0]  = a;
        r[15:8] = b;
        return r;
    endfunction

    task automatic send_report(input logic [8*NS-1:0] k);
        @(posedge Clk); #1;
        keycodes = k;
        keycode_valid = 1'b1;
        @(posedge Clk); #1;
        keycode_valid = 1'b0;
    endtask

    task automatic frame(input logic [NP-1:0] ack_at_tick);
        @(posedge Clk); #1;
        frame_clk = 1'b1;
        repeat (3) @(posedge Clk);
        #1 jump_ack = ack_at_tick;
        @(posedge Clk); #1;
        jump_ack = '0;
        repeat (2) @(posedge Clk);
        #1 frame_clk = 1'b0;
        repeat (4) @(posedge Clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(posedge Clk); #1;
        Reset_n = 1'b0;
        keycode_valid = 1'b0;
        jump_ack = '0;
        frame_clk = 1'b0;
        @(posedge Clk); #1;
        Reset_n = 1'b1;
    endtask

    task automatic model_reset();
        for (int s = 0; s < NS; s++) m_rep[s] = 8'h00;
        for (int p = 0; p < NP; p++) begin
            m_dir[p] = 0;
            m_jreq[p] = 0;
            m_jcnt[p] = 0;
            for (int a = 0; a < 3; a++) m_prev[p][a] = 0;
        end
        m_since = 0;
    endtask

    function automatic bit m_hit(input int p, input int a);
        for (int s = 0; s < NS; s++)
            if (m_rep[s] == km(p, a)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_report(input logic [8*NS-1:0] k);
        for (int s = 0; s < NS; s++)
            if (k[8*s +: 8] == 8'h01) return;
        for (int s = 0; s < NS; s++) m_rep[s] = k[8*s +: 8];
        m_since = 0;
    endtask

    // dir: 0 idle, 1 left, 2 right
    task automatic model_tick();
        bit h [3];
        bit n [3];
        for (int p = 0; p < NP; p++) begin
            for (int a = 0; a < 3; a++) begin
                h[a] = m_hit(p, a);
                n[a] = h[a] && !m_prev[p][a];
            end
            if (h[0] && !h[1]) m_dir[p] = 1;
            else if (h[1] && !h[0]) m_dir[p] = 2;
            else if (!h[0] && !h[1]) m_dir[p] = 0;
            else if (n[0] && !n[1]) m_dir[p] = 1;
            else if (n[1] && !n[0]) m_dir[p] = 2;
            if (n[2]) begin
                m_jreq[p] = 1;
                m_jcnt[p] = JBF;
            end else if (m_jreq[p]) begin
                m_jcnt[p]--;
                if (m_jcnt[p] == 0) m_jreq[p] = 0;
            end
            for (int a = 0; a < 3; a++) m_prev[p][a] = h[a];
        end
`ifdef STUCK_KEY_TIMEOUT_EN
        if (m_since < 255) m_since++;
        if (m_since == SF)
            for (int s = 0; s < NS; s++) m_rep[s] = 8'h00;
`endif
    endtask

    task automatic test_reset();
        repeat (2) @(posedge Clk);
        #1;
        checks++; if (move_left !== 4'b0000) begin fails++; $display("FAIL reset_ml: got %b want 0000", move_left); end
        checks++; if (move_right !== 4'b0000) begin fails++; $display("FAIL reset_mr: got %b want 0000", move_right); end
        checks++; if (jump_req !== 4'b0000) begin fails++; $display("FAIL reset_jr: got %b want 0000", jump_req); end
        checks++; if (any_key !== 1'b0) begin fails++; $display("FAIL reset_any: got %b want 0", any_key); end
        Reset_n = 1'b1;
        send_report(mk(8'h52, 8'h00));
        frame('0);
        checks++; if (jump_req !== 4'b0001) begin fails++; $display("FAIL pre_reset_jr: got %b want 0001", jump_req); end
        @(posedge Clk); #5;
        Reset_n = 1'b0;
        #1;
        checks++; if (jump_req !== 4'b0000) begin fails++; $display("FAIL async_reset_jr: got %b want 0000", jump_req); end
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        send_report(mk(8'h04, 8'h00));
        checks++; if (move_left !== 4'b0000) begin fails++; $display("FAIL pre_tick_ml: got %b want 0000", move_left); end
        frame('0);
        checks++; if (move_left !== 4'b0010) begin fails++; $display("FAIL post_reset_ml: got %b want 0010", move_left); end
    endtask

    task automatic test_direction();
        logic [8*NS-1:0] seq [6];
        logic [NP-1:0]   eml [6];
        logic [NP-1:0]   emr [6];
        seq = '{mk(8'h50, 8'h00), mk(8'h50, 8'h4F), mk(8'h4F, 8'h50), mk(8'h50, 8'h00), mk(8'h00, 8'h00), mk(8'h50, 8'h4F)};
        eml = '{4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
        emr = '{4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        for (int i = 0; i < 6; i++) begin
            send_report(seq[i]);
            frame('0);
            checks++; if (move_left !== eml[i]) begin fails++; $display("FAIL dir_ml step %0d: got %b want %b", i, move_left, eml[i]); end
            checks++; if (move_right !== emr[i]) begin fails++; $display("FAIL dir_mr step %0d: got %b want %b", i, move_right, emr[i]); end
        end
    endtask

    task automatic test_jump_buffer();
        pulse_reset();
        send_report(mk(8'h52, 8'h00));
        frame('0);
        checks++; if (jump_req !== 4'b0001) begin fails++; $display("FAIL jump_set: got %b want 0001", jump_req); end
        for (int k = 1; k <= JBF + 1; k++) begin
            logic [NP-1:0] e;
            e = (k < JBF) ? 4'b0001 : 4'b0000;
            frame('0);
            checks++; if (jump_req !== e) begin fails++; $display("FAIL jump_hold tick %0d: got %b want %b", k, jump_req, e); end
        end
        send_report(mk(8'h00, 8'h00));
        frame('0);
        send_report(mk(8'h52, 8'h00));
        frame('0);
        checks++; if (jump_req !== 4'b0001) begin fails++; $display("FAIL jump_repress: got %b want 0001", jump_req); end
    endtask

    task automatic test_jump_ack();
        pulse_reset();
        send_report(mk(8'h1A, 8'h00));
        frame('0);
        checks++; if (jump_req !== 4'b0010) begin fails++; $display("FAIL ack_pre: got %b want 0010", jump_req); end
        @(posedge Clk); #1;
        jump_ack = 4'b0010;
        @(posedge Clk); #1;
        jump_ack = 4'b0000;
        checks++; if (jump_req !== 4'b0000) begin fails++; $display("FAIL ack_clear: got %b want 0000", jump_req); end
        send_report(mk(8'h00, 8'h00));
        frame('0);
        send_report(mk(8'h1A, 8'h00));
        frame('0);
        send_report(mk(8'h00, 8'h00));
        frame('0);
        send_report(mk(8'h1A, 8'h00));
        frame(4'b0010);
        checks++; if (jump_req !== 4'b0010) begin fails++; $display("FAIL ack_vs_press: got %b want 0010", jump_req); end
        for (int k = 1; k <= JBF; k++) begin
            logic [NP-1:0] e;
            e = (k < JBF) ? 4'b0010 : 4'b0000;
            frame('0);
            checks++; if (jump_req !== e) begin fails++; $display("FAIL ack_reload tick %0d: got %b want %b", k, jump_req, e); end
        end
    endtask

    task automatic test_rollover_any_key();
        pulse_reset();
        send_report(mk(8'h07, 8'h00));
        frame('0);
        checks++; if (move_right !== 4'b0010) begin fails++; $display("FAIL roll_pre: got %b want 0010", move_right); end
        send_report({NS{8'h01}});
        frame('0);
        checks++; if (move_right !== 4'b0010) begin fails++; $display("FAIL roll_all: got %b want 0010", move_right); end
        send_report(mk(8'h4F, 8'h01));
        frame('0);
        checks++; if (move_right !== 4'b0010) begin fails++; $display("FAIL roll_mixed: got %b want 0010", move_right); end
        send_report(mk(8'h00, 8'h00));
        @(posedge Clk); #1;
        checks++; if (any_key !== 1'b0) begin fails++; $display("FAIL any_on_release: got %b want 0", any_key); end
        send_report({NS{8'h01}});
        checks++; if (any_key !== 1'b0) begin fails++; $display("FAIL any_on_rollover: got %b want 0", any_key); end
        @(posedge Clk); #1;
        keycodes = mk(8'h1A, 8'h00);
        keycode_valid = 1'b1;
        checks++; if (any_key !== 1'b0) begin fails++; $display("FAIL any_before: got %b want 0", any_key); end
        @(posedge Clk); #1;
        keycode_valid = 1'b0;
        checks++; if (any_key !== 1'b1) begin fails++; $display("FAIL any_pulse: got %b want 1", any_key); end
        @(posedge Clk); #1;
        checks++; if (any_key !== 1'b0) begin fails++; $display("FAIL any_width: got %b want 0", any_key); end
    endtask

    task automatic test_stuck_timeout();
        pulse_reset();
        send_report(mk(8'h50, 8'h00));
        for (int k = 1; k <= 5; k++) begin
            logic e;
`ifdef STUCK_KEY_TIMEOUT_EN
            e = (k < SF + 1);
`else
            e = 1'b1;
`endif
            frame('0);
            checks++; if (move_left[0] !== e) begin fails++; $display("FAIL stuck tick %0d: got %b want %b", k, move_left[0], e); end
        end
    endtask

    task automatic test_random();
        logic [NP-1:0] eml, emr, ejr, mask;
        logic [8*NS-1:0] k;
        int r;
        pulse_reset();
        model_reset();
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) != 0) begin
                for (int s = 0; s < NS; s++) begin
                    r = $urandom_range(0, 15);
                    if (r < 12) k[8*s +: 8] = km(r / 3, r % 3);
                    else if (r == 12) k[8*s +: 8] = 8'h01;
                    else if (r == 13) k[8*s +: 8] = 8'h2C;
                    else k[8*s +: 8] = 8'h00;
                end
                send_report(k);
                model_report(k);
            end
            frame('0);
            model_tick();
            for (int p = 0; p < NP; p++) begin
                eml[p] = (m_dir[p] == 1);
                emr[p] = (m_dir[p] == 2);
                ejr[p] = m_jreq[p];
            end
            checks++; if (move_left !== eml) begin fails++; $display("FAIL rand_ml %0d: got %b want %b", i, move_left, eml); end
            checks++; if (move_right !== emr) begin fails++; $display("FAIL rand_mr %0d: got %b want %b", i, move_right, emr); end
            checks++; if (jump_req !== ejr) begin fails++; $display("FAIL rand_jr %0d: got %b want %b", i, jump_req, ejr); end
            if ($urandom_range(0, 3) == 0) begin
                mask = NP'($urandom);
                @(posedge Clk); #1;
                jump_ack = mask;
                @(posedge Clk); #1;
                jump_ack = '0;
                for (int p = 0; p < NP; p++)
                    if (mask[p] && m_jreq[p]) begin
                        m_jreq[p] = 0;
                        m_jcnt[p] = 0;
                    end
                for (int p = 0; p < NP; p++) ejr[p] = m_jreq[p];
                checks++; if (jump_req !== ejr) begin fails++; $display("FAIL rand_ack %0d: got %b want %b", i, jump_req, ejr); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_direction();
        test_jump_buffer();
        test_jump_ack();
        test_rollover_any_key();
        test_stuck_timeout();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
